// File: rtl/avr_fdc_bus_master.sv
// Bus initiator for the CPLD FDC responder: turns single-byte read/write
// commands into timed a_sel request/fetch cycles on the AVR parallel bus.
module avr_fdc_bus_master #(
   parameter int SEL_TICKS    = 4,
   parameter int HOLD_TICKS   = 4,
   parameter int SETTLE_TICKS = 20,
   parameter int FETCH_TICKS  = 4
) (
   input  logic        clock_50,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_rw,
   input  logic [15:0] cmd_addr,
   input  logic [7:0]  cmd_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        a_sel,
   output logic        a_rw,
   output logic [15:0] a_addrbus,
   inout  wire  [7:0]  a_databus,
   input  logic [1:0]  intr_in,
   output logic [1:0]  intr_sync,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_ASSERT, S_HOLD, S_SETTLE1, S_FETCH, S_HOLD2, S_SETTLE2
   } state_t;

   state_t      r_state, w_next;
   logic [7:0]  r_tcnt, w_load;
   logic        r_sel, r_rw, r_rsp_valid;
   logic [15:0] r_addr;
   logic [7:0]  r_wbuf, r_rdata;
   logic [1:0]  r_intr_meta, r_intr_sync;
   logic        w_tdone, w_accept, w_rsp, w_capture;

   assign w_tdone  = (r_tcnt == 8'd0);
   assign w_accept = cmd_valid && (r_state == S_IDLE);

   always_comb begin
      w_next    = r_state;
      w_rsp     = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         S_IDLE:    if (cmd_valid) w_next = S_ASSERT;
         S_ASSERT:  if (w_tdone) w_next = S_HOLD;
         S_HOLD:    if (w_tdone) w_next = S_SETTLE1;
         S_SETTLE1: if (w_tdone) begin
            if (r_rw) begin
               w_next = S_FETCH;
            end else begin
               w_next = S_IDLE;
               w_rsp  = 1'b1;
            end
         end
         S_FETCH:   if (w_tdone) begin
            w_next    = S_HOLD2;
            w_capture = 1'b1;
         end
         S_HOLD2:   if (w_tdone) w_next = S_SETTLE2;
         S_SETTLE2: if (w_tdone) begin
            w_next = S_IDLE;
            w_rsp  = 1'b1;
         end
         default:   w_next = S_IDLE;
      endcase
   end

   // Phase length for whichever state is being entered; counts down to 0.
   always_comb begin
      w_load = 8'd0;
      case (w_next)
         S_ASSERT:             w_load = 8'(SEL_TICKS - 1);
         S_HOLD, S_HOLD2:      w_load = 8'(HOLD_TICKS - 1);
         S_SETTLE1, S_SETTLE2: w_load = 8'(SETTLE_TICKS - 1);
         S_FETCH:              w_load = 8'(FETCH_TICKS - 1);
         default:              w_load = 8'd0;
      endcase
   end

   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_tcnt      <= 8'd0;
         r_sel       <= 1'b0;
         r_rw        <= 1'b1;
         r_addr      <= 16'd0;
         r_wbuf      <= 8'd0;
         r_rsp_valid <= 1'b0;
         r_rdata     <= 8'd0;
      end else begin
         r_state     <= w_next;
         r_rsp_valid <= w_rsp;
         if (r_state != w_next)
            r_tcnt <= w_load;
         else if (!w_tdone)
            r_tcnt <= r_tcnt - 8'd1;
         // a_sel is registered from next state so the responder sees a clean edge
         r_sel <= (w_next == S_ASSERT) || (w_next == S_FETCH);
         if (w_capture) r_rdata <= a_databus;
         if (w_accept) begin
            r_rw   <= cmd_rw;
            r_addr <= cmd_addr;
            r_wbuf <= cmd_wdata;
         end
      end
   end

   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         r_intr_meta <= 2'b00;
         r_intr_sync <= 2'b00;
      end else begin
         r_intr_meta <= intr_in;
         r_intr_sync <= r_intr_meta;
      end
   end

   assign cmd_ready = (r_state == S_IDLE) && reset_n;
   assign busy      = (r_state != S_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rdata;
   assign a_sel     = r_sel;
   assign a_rw      = r_rw;
   assign a_addrbus = r_addr;
   assign intr_sync = r_intr_sync;
   // Released in the same cycle a_rw goes high, so the responder never contends.
   assign a_databus = r_rw ? 8'bz : r_wbuf;

endmodule

// File: tb/tb_avr_fdc_bus_master.sv
// Bench for avr_fdc_bus_master: responder model plus a response scoreboard,
// with a second instance at minimum phase lengths.
module tb_avr_fdc_bus_master;

   logic clock_50 = 1'b0;
   logic reset_n  = 1'b1;
   always #10 clock_50 = ~clock_50;

   logic        cmd_valid = 1'b0, cmd_rw = 1'b0;
   logic [15:0] cmd_addr = 16'd0;
   logic [7:0]  cmd_wdata = 8'd0;
   logic        cmd_ready, rsp_valid, a_sel, a_rw, busy;
   logic [7:0]  rsp_rdata;
   logic [15:0] a_addrbus;
   logic [1:0]  intr_in = 2'b00, intr_sync;
   wire  [7:0]  a_databus;

   avr_fdc_bus_master dut (
      .clock_50(clock_50), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .a_sel(a_sel), .a_rw(a_rw), .a_addrbus(a_addrbus),
      .a_databus(a_databus), .intr_in(intr_in), .intr_sync(intr_sync), .busy(busy));

   logic        c2_valid = 1'b0, c2_rw = 1'b0;
   logic [15:0] c2_addr = 16'd0;
   logic [7:0]  c2_wdata = 8'd0;
   logic        c2_ready, rsp_valid2, a_sel2, a_rw2, busy2;
   logic [7:0]  rsp_rdata2;
   logic [15:0] a_addrbus2;
   logic [1:0]  intr_sync2;
   wire  [7:0]  a_databus2;

   avr_fdc_bus_master #(.SEL_TICKS(1), .HOLD_TICKS(3), .SETTLE_TICKS(1), .FETCH_TICKS(1)) dut2 (
      .clock_50(clock_50), .reset_n(reset_n), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
      .cmd_rw(c2_rw), .cmd_addr(c2_addr), .cmd_wdata(c2_wdata), .rsp_valid(rsp_valid2),
      .rsp_rdata(rsp_rdata2), .a_sel(a_sel2), .a_rw(a_rw2), .a_addrbus(a_addrbus2),
      .a_databus(a_databus2), .intr_in(2'b00), .intr_sync(intr_sync2), .busy(busy2));

   assign a_databus2 = (a_sel2 && a_rw2) ? 8'h96 : 8'bz;

   // Responder model: 3-flop a_sel sync, acts on the falling edge, read data
   // appears 10 cycles after the request is seen.
   logic       s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
   logic [7:0] readbuf = 8'h00, lat_lo = 8'h00;
   int         ld_cnt = 0, req_cnt = 0;

   always @(posedge clock_50) begin
      s1 <= a_sel; s2 <= s1; s3 <= s2;
      if (s3 && !s2) begin
         req_cnt <= req_cnt + 1;
         lat_lo  <= a_addrbus[7:0];
         if (a_rw) begin
            readbuf <= 8'h00;
            ld_cnt  <= 10;
         end
      end else if (ld_cnt > 0) begin
         ld_cnt <= ld_cnt - 1;
         if (ld_cnt == 1) readbuf <= 8'h3C ^ lat_lo;
      end
   end

   assign a_databus = (a_sel && a_rw) ? readbuf : 8'bz;

   typedef struct { int lat; logic [7:0] rdata; } rec_t;
   rec_t exp_q[$], obs_q[$];
   rec_t m_o, ob, ex;
   int   hs_q[$], hs_log[$], rsp_log[$];
   int   cyc = 0, bus_chk = 0, bus_bad = 0;
   int   nvec = 0, nbad = 0;
   logic [7:0] last_rd = 8'h00;

   // Monitor: handshake times, responses and bus contention, sampled at negedge.
   initial forever begin
      @(negedge clock_50);
      cyc++;
      if (!reset_n) begin
         hs_q.delete();
      end else begin
         if (cmd_valid && cmd_ready) begin
            hs_q.push_back(cyc);
            hs_log.push_back(cyc);
         end
         if (rsp_valid) begin
            m_o.lat   = (hs_q.size() > 0) ? cyc - hs_q.pop_front() : -1;
            m_o.rdata = rsp_rdata;
            obs_q.push_back(m_o);
            rsp_log.push_back(cyc);
         end
         if (a_sel && a_rw) begin
            bus_chk++;
            if (a_databus !== readbuf) bus_bad++;
         end
      end
   end

   task automatic issue(input logic rw, input logic [15:0] addr, input logic [7:0] wd);
      @(posedge clock_50); #1;
      cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_wdata = wd;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock_50);
         if (cmd_ready) break;
      end
      @(posedge clock_50); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_obs(output bit got);
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (obs_q.size() > 0) begin
            got = 1'b1;
            break;
         end
         @(negedge clock_50);
      end
   endtask

   task automatic test_reset;
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clock_50);
      nvec++;
      if (a_sel !== 1'b0 || a_rw !== 1'b1 || a_addrbus !== 16'h0000 || busy !== 1'b0) begin
         nbad++;
         $display("FAIL reset_bus: sel=%b rw=%b addr=%h busy=%b, want 0 1 0000 0", a_sel, a_rw, a_addrbus, busy);
      end
      nvec++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 || intr_sync !== 2'b00) begin
         nbad++;
         $display("FAIL reset_cmd: ready=%b rsp=%b rdata=%h intr=%b, want 0 0 00 00", cmd_ready, rsp_valid, rsp_rdata, intr_sync);
      end
      nvec++;
      if (a_sel2 !== 1'b0 || a_addrbus2 !== 16'h0000 || busy2 !== 1'b0 || intr_sync2 !== 2'b00) begin
         nbad++;
         $display("FAIL reset_dut2: sel=%b addr=%h busy=%b intr=%b", a_sel2, a_addrbus2, busy2, intr_sync2);
      end
      reset_n = 1'b1;
      @(negedge clock_50);
      nvec++;
      if (cmd_ready !== 1'b1) begin
         nbad++;
         $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_write;
      int n = 0, bad = 0, r0;
      bit got;
      r0 = req_cnt;
      exp_q.push_back('{lat: 29, rdata: last_rd});
      issue(1'b0, 16'h1234, 8'hA5);
      @(negedge clock_50);
      while (a_sel && n < 20) begin
         if (a_addrbus !== 16'h1234 || a_databus !== 8'hA5 || a_rw !== 1'b0) bad++;
         n++;
         @(negedge clock_50);
      end
      for (int k = 0; k < 4; k++) begin
         if (a_sel !== 1'b0 || a_addrbus !== 16'h1234 || a_databus !== 8'hA5 || a_rw !== 1'b0) bad++;
         @(negedge clock_50);
      end
      nvec++;
      if (n !== 4) begin nbad++; $display("FAIL write_sel_len: got %0d want 4", n); end
      nvec++;
      if (bad !== 0) begin nbad++; $display("FAIL write_bus_hold: %0d bad cycles, want 0", bad); end
      wait_obs(got);
      nvec++;
      if (!got) begin
         nbad++; $display("FAIL write_rsp: no response, want one");
      end else begin
         ob = obs_q.pop_front(); ex = exp_q.pop_front();
         if (ob.lat !== ex.lat || ob.rdata !== ex.rdata) begin
            nbad++; $display("FAIL write_rsp: lat=%0d rdata=%h, want %0d %h", ob.lat, ob.rdata, ex.lat, ex.rdata);
         end
      end
      repeat (4) @(negedge clock_50);
      nvec++;
      if (req_cnt - r0 !== 1) begin nbad++; $display("FAIL write_reqs: got %0d want 1", req_cnt - r0); end
   endtask

   task automatic test_read(input logic [15:0] addr, input string nm);
      int r0, b0, c0;
      bit got;
      r0 = req_cnt; b0 = bus_bad; c0 = bus_chk;
      exp_q.push_back('{lat: 57, rdata: 8'h3C ^ addr[7:0]});
      issue(1'b1, addr, 8'hFF);
      wait_obs(got);
      nvec++;
      if (!got) begin
         nbad++; $display("FAIL %s_rsp: no response, want one", nm);
      end else begin
         ob = obs_q.pop_front(); ex = exp_q.pop_front();
         if (ob.lat !== ex.lat || ob.rdata !== ex.rdata) begin
            nbad++; $display("FAIL %s_rsp: lat=%0d rdata=%h, want %0d %h", nm, ob.lat, ob.rdata, ex.lat, ex.rdata);
         end
         last_rd = ex.rdata;
      end
      repeat (5) @(negedge clock_50);
      nvec++;
      if (req_cnt - r0 !== 2) begin nbad++; $display("FAIL %s_falls: got %0d want 2", nm, req_cnt - r0); end
      nvec++;
      if (bus_bad - b0 !== 0 || bus_chk - c0 !== 8) begin
         nbad++; $display("FAIL %s_bus_drive: contended=%0d sel_cycles=%0d, want 0 8", nm, bus_bad - b0, bus_chk - c0);
      end
   endtask

   task automatic test_back_to_back;
      int h, rl, r0;
      bit got;
      h = hs_log.size(); rl = rsp_log.size(); r0 = req_cnt;
      exp_q.push_back('{lat: 29, rdata: last_rd});
      exp_q.push_back('{lat: 29, rdata: last_rd});
      @(posedge clock_50); #1;
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 16'h0011; cmd_wdata = 8'h5A;
      for (int i = 0; i < 200; i++) begin @(negedge clock_50); if (cmd_ready) break; end
      @(posedge clock_50); #1;
      cmd_addr = 16'h0000; cmd_wdata = 8'hC3;
      for (int i = 0; i < 200; i++) begin @(negedge clock_50); if (cmd_ready) break; end
      @(posedge clock_50); #1;
      cmd_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         wait_obs(got);
         nvec++;
         if (!got) begin
            nbad++; $display("FAIL b2b_rsp%0d: no response, want one", k);
         end else begin
            ob = obs_q.pop_front(); ex = exp_q.pop_front();
            if (ob.lat !== ex.lat) begin
               nbad++; $display("FAIL b2b_rsp%0d: lat=%0d want %0d", k, ob.lat, ex.lat);
            end
         end
      end
      repeat (5) @(negedge clock_50);
      nvec++;
      if (hs_log.size() < h + 2 || rsp_log.size() < rl + 1) begin
         nbad++; $display("FAIL b2b_spacing: handshakes=%0d rsps=%0d, want 2 1", hs_log.size() - h, rsp_log.size() - rl);
      end else if (hs_log[h+1] < rsp_log[rl] || hs_log[h+1] - hs_log[h] < 29) begin
         nbad++; $display("FAIL b2b_spacing: gap=%0d hs2=%0d rsp1=%0d, want gap>=29 hs2>=rsp1",
                          hs_log[h+1] - hs_log[h], hs_log[h+1], rsp_log[rl]);
      end
      nvec++;
      if (req_cnt - r0 !== 2) begin nbad++; $display("FAIL b2b_reqs: got %0d want 2", req_cnt - r0); end
   endtask

   task automatic test_intr;
      bit got;
      exp_q.push_back('{lat: 29, rdata: last_rd});
      issue(1'b0, 16'h2000, 8'h11);
      intr_in = 2'b10;
      @(posedge clock_50); #1;
      nvec++;
      if (intr_sync !== 2'b00) begin nbad++; $display("FAIL intr_1cyc: got %b want 00", intr_sync); end
      @(posedge clock_50); #1;
      nvec++;
      if (intr_sync !== 2'b10 || busy !== 1'b1) begin
         nbad++; $display("FAIL intr_2cyc: intr=%b busy=%b, want 10 1", intr_sync, busy);
      end
      wait_obs(got);
      nvec++;
      if (!got) begin
         nbad++; $display("FAIL intr_rsp: no response, want one");
      end else begin
         ob = obs_q.pop_front(); ex = exp_q.pop_front();
         if (ob.lat !== ex.lat) begin nbad++; $display("FAIL intr_rsp: lat=%0d want %0d", ob.lat, ex.lat); end
      end
      intr_in = 2'b00;
   endtask

   task automatic test_reset_mid_fetch;
      int rises = 0;
      logic prev = 1'b0;
      issue(1'b1, 16'h0100, 8'hFF);
      for (int i = 0; i < 100 && rises < 2; i++) begin
         @(negedge clock_50);
         if (a_sel && !prev) rises++;
         prev = a_sel;
      end
      nvec++;
      if (rises !== 2) begin nbad++; $display("FAIL rst_fetch_reach: rises=%0d want 2", rises); end
      #3 reset_n = 1'b0;
      #1;
      nvec++;
      if (a_sel !== 1'b0 || a_rw !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
         nbad++; $display("FAIL rst_fetch_abort: sel=%b rw=%b rsp=%b busy=%b ready=%b, want 0 1 0 0 0",
                          a_sel, a_rw, rsp_valid, busy, cmd_ready);
      end
      repeat (2) @(negedge clock_50);
      reset_n = 1'b1;
      @(negedge clock_50);
      nvec++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || obs_q.size() !== 0) begin
         nbad++; $display("FAIL rst_fetch_idle: ready=%b busy=%b rsps=%0d, want 1 0 0", cmd_ready, busy, obs_q.size());
      end
      repeat (10) @(negedge clock_50);
      test_read(16'h2042, "post_rst_read");
   endtask

   task automatic test_params;
      logic [15:0] seen = 16'h0000;
      int lat = -1;
      @(posedge clock_50); #1;
      c2_valid = 1'b1; c2_rw = 1'b1; c2_addr = 16'h0100; c2_wdata = 8'hFF;
      for (int i = 0; i < 50; i++) begin @(negedge clock_50); if (c2_ready) break; end
      @(posedge clock_50); #1;
      c2_valid = 1'b0;
      for (int k = 1; k < 16; k++) begin
         @(negedge clock_50);
         if (rsp_valid2) begin lat = k; break; end
         seen[k] = a_sel2;
      end
      nvec++;
      if (seen !== 16'h0042) begin nbad++; $display("FAIL param_sel_pattern: got %h want 0042", seen); end
      nvec++;
      if (lat !== 11) begin nbad++; $display("FAIL param_latency: got %0d want 11", lat); end
      nvec++;
      if (rsp_rdata2 !== 8'h96) begin nbad++; $display("FAIL param_rdata: got %h want 96", rsp_rdata2); end
   endtask

   initial begin
      test_reset;
      test_write;
      test_read(16'h0100, "read");
      test_back_to_back;
      test_intr;
      test_reset_mid_fetch;
      test_params;
      nvec++;
      if (exp_q.size() !== 0 || obs_q.size() !== 0) begin
         nbad++; $display("FAIL scoreboard_drain: exp=%0d obs=%0d left, want 0 0", exp_q.size(), obs_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

   initial begin
      #2000000;
      nbad++;
      $display("FAIL watchdog: run exceeded time limit");
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule

// File: doc/avr_fdc_bus_master.md
Name: avr_fdc_bus_master

Overview:
- Host-side initiator for the parallel AVR register/SRAM bus (a_sel, a_rw, a_addrbus, a_databus) served by the CPLD FDC emulator.
- Accepts single-byte read and write commands from the AVR-side logic over a valid/ready handshake.
- Sequences the bus timing the CPLD responder requires:
  - The responder synchronises a_sel through 3 flops and acts on the falling edge of a_sel.
  - The responder drives a_databus while a_sel=1 and a_rw=1.
- Returns read data with a response strobe. Also synchronises the responder's intr[1:0] lines.

Parameters:
- SEL_TICKS, 4, clock_50 cycles a_sel is held high in the request phase (1..255).
- HOLD_TICKS, 4, cycles addr/rw/data are held after a_sel falls; must be ≥3 to cover the responder's synchroniser (1..255).
- SETTLE_TICKS, 20, cycles of wait after each falling edge so the responder drains its single pending-request flag; covers a worst-case 6-tick CTS cycle, arbitration and a 4-tick SRAM access (1..255).
- FETCH_TICKS, 4, cycles a_sel is high in the read-fetch phase; data is sampled on the last of these (1..255).

Ports:
- clock_50  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_rw  in  1  1=read, 0=write
- cmd_addr  in  16  responder address (0x0000=$ff40, 0x0011=$ff48, 0x0100=control, else SRAM)
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse: command complete
- rsp_rdata  out  8  read data; valid with rsp_valid for reads, holds its value otherwise
- a_sel  out  1  bus select to responder
- a_rw  out  1  bus direction
- a_addrbus  out  16  bus address
- a_databus  inout  8  driven by this block only when a_rw=0, else high-Z
- intr_in  in  2  responder intr lines
- intr_sync  out  2  intr_in after a 2-flop synchroniser
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE.
  - a_sel=0, a_rw=1, a_addrbus=0, a_databus=Z.
  - cmd_ready=0 during reset, then 1 in IDLE.
  - rsp_valid=0, rsp_rdata=0, intr_sync=0, busy=0.
  - Reset mid-transaction aborts immediately with no response. A partially issued request may still be acted on by the responder.
- Single 8-bit down-counter tcnt, loaded on each state entry with (param-1), advancing at tcnt=0.
- IDLE: cmd_ready=1. On handshake:
  - Register cmd_rw, cmd_addr and cmd_wdata onto a_rw, a_addrbus and the write buffer.
  - Go to ASSERT; a_sel rises on the next edge.
  - Bus outputs stay stable from acceptance until the end of HOLD.
- ASSERT: a_sel=1 for SEL_TICKS cycles, then a_sel=0 and go to HOLD. This falling edge is the request.
- HOLD: a_sel=0, all bus outputs unchanged for HOLD_TICKS cycles, then go to SETTLE1.
- SETTLE1: idle bus for SETTLE_TICKS cycles.
  - Write: pulse rsp_valid and go to IDLE.
  - Read: go to FETCH.
- FETCH:
  - a_sel=1, a_rw=1, same a_addrbus, a_databus=Z, for FETCH_TICKS cycles.
  - On the last cycle, capture a_databus into rsp_rdata.
  - Then a_sel=0 and go to HOLD2.
- HOLD2: HOLD_TICKS cycles, then SETTLE2.
  - The fetch falling edge causes a second, idempotent read at the same address; it re-clears intr for 0x0000/0x0011.
- SETTLE2: SETTLE_TICKS cycles, then pulse rsp_valid and go to IDLE.
- cmd_ready is 0 in every state except IDLE. Back-to-back commands are therefore spaced by at least one IDLE cycle, which guarantees one falling edge per responder service.
- Latency from handshake to rsp_valid:
  - Write: SEL+HOLD+SETTLE+1 cycles = 29 at defaults.
  - Read: 2·HOLD+2·SETTLE+SEL+FETCH+1 cycles = 57 at defaults.
- a_databus is released (Z) in the same cycle a_rw goes to 1; this block never drives it while a_rw=1.
- intr_sync is free-running and independent of the state machine.

Test Plan:
- Write: cmd addr=0x1234, wdata=0xA5, rw=0.
  - Required: a_sel high exactly 4 cycles with a_addrbus=0x1234 and a_databus=0xA5 held through 4 cycles after the fall.
  - Required: rsp_valid 29 cycles after the handshake.
- Read with a responder model (3-flop sync on a_sel; readbuf=0x3C loaded 10 cycles after the fall).
  - Required: rsp_rdata=0x3C with rsp_valid at cycle 57.
  - Required: exactly two a_sel falling edges.
  - Required: a_databus is never driven by this block.
- Back-to-back: two writes with cmd_valid held high.
  - Required: the second handshake only after the first rsp_valid plus one IDLE cycle.
  - Required: the responder model counts 2 requests, none merged.
- Reset mid-FETCH: assert reset_n=0.
  - Required: a_sel=0, a_databus=Z, rsp_valid=0 immediately.
  - Required: after release, IDLE with cmd_ready=1 and the next command completes normally.
- Parameters SEL=1, HOLD=3, SETTLE=1, FETCH=1 on a read.
  - Required: phase lengths exactly 1/3/1/1/3/1 cycles and correct data capture.
- intr_in toggled from 00 to 10.
  - Required: intr_sync=10 two cycles later, including while busy=1.
